// File: rtl/serial_add_sequencer.sv
// Operand FIFO plus single-op issue FSM in front of serial_adder: one start pulse per pair,
// result held on a valid/ready port. Optional WAIT timeout is built when SEQ_TIMEOUT_EN is defined.
module serial_add_sequencer #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic                     add_start,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  input  logic [WIDTH-1:0]         add_sum,
  input  logic                     add_done,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_sum,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy,
  output logic                     timeout_err,
  output logic [1:0]               dbg_state
);

  // Both ports use valid/ready: a transfer happens on a rising edge where valid and ready
  // are both 1; valid and data stay stable until that edge, and ready never depends on valid.

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t              state;
  logic [2*WIDTH-1:0]  mem [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic [2*WIDTH-1:0]  head;
  logic                done_q;
  logic                done_rise;

  // The extra pointer bit distinguishes full from empty when the index bits match.
  assign full       = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty      = (wr_ptr == rd_ptr);
  assign in_ready   = !full;
  assign push       = in_valid && in_ready;
  assign pop        = (state == ISSUE);
  assign head       = mem[rd_ptr[AW-1:0]];
  assign fifo_count = wr_ptr - rd_ptr;
  assign busy       = (state != IDLE);
  assign dbg_state  = state;
  assign done_rise  = add_done && !done_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {in_a, in_b};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign timeout_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      add_start <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      res_valid <= 1'b0;
      res_sum   <= '0;
      done_q    <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      done_q    <= add_done;
      add_start <= 1'b0;
      case (state)
        IDLE: begin
          // Operands are registered on entry so they are valid alongside the start pulse.
          if (!empty) begin
            state     <= ISSUE;
            add_start <= 1'b1;
            add_a     <= head[2*WIDTH-1:WIDTH];
            add_b     <= head[WIDTH-1:0];
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef SEQ_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (done_rise) begin
            res_sum   <= add_sum;
            res_valid <= 1'b1;
            state     <= HOLD;
          end
`ifdef SEQ_TIMEOUT_EN
          else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            res_sum     <= '0;
            res_valid   <= 1'b1;
            timeout_err <= 1'b1;
            state       <= HOLD;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed bench for serial_add_sequencer with a behavioural serial_adder model and
// queue-based scoreboards for issued operands and returned sums.
module tb_serial_add_sequencer;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          add_start;
  logic [W-1:0]  add_a;
  logic [W-1:0]  add_b;
  logic [W-1:0]  add_sum;
  logic          add_done;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [W-1:0]  res_sum;
  logic [2:0]    fifo_count;
  logic          busy;
  logic          timeout_err;
  logic [1:0]    dbg_state;

  serial_add_sequencer #(.WIDTH(W), .DEPTH(4), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .add_start(add_start), .add_a(add_a), .add_b(add_b),
    .add_sum(add_sum), .add_done(add_done), .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .fifo_count(fifo_count), .busy(busy), .timeout_err(timeout_err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // adder model: done rises 17 cycles after start and stays high until the next start
  logic          stale_mode = 1'b0;
  logic          never_done = 1'b0;
  logic [W-1:0]  m_nxt;
  logic          m_run;
  int            m_cnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      add_done <= 1'b0; add_sum <= '0; m_run <= 1'b0; m_cnt <= 0; m_nxt <= '0;
    end else if (add_start) begin
      m_run <= 1'b1; m_cnt <= 1; m_nxt <= add_a + add_b;
      if (!stale_mode) add_done <= 1'b0;
    end else if (m_run) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 4) add_done <= 1'b0;
      if (m_cnt == 16 && !never_done) begin
        add_done <= 1'b1; add_sum <= m_nxt; m_run <= 1'b0;
      end
    end
  end

  // scoreboard
  logic [W-1:0]   exp_q[$];
  logic [2*W-1:0] exp_a_q[$];
  int checks = 0;
  int failures = 0;
  logic exp_err = 1'b0;
  int hs_cnt = 0, res_seen = 0, start_cyc = 0, first_valid_cyc = 0, acc_cyc = 0;
  logic prev_start = 1'b0, prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (reset) begin
      if (add_start) begin
        check("start_single_cycle", {31'd0, prev_start}, 32'd0);
        start_cyc = cyc;
        if (exp_a_q.size() == 0) check("start_unexpected", 32'd1, 32'd0);
        else begin
          logic [2*W-1:0] e;
          e = exp_a_q.pop_front();
          check("add_a", {16'd0, add_a}, {16'd0, e[2*W-1:W]});
          check("add_b", {16'd0, add_b}, {16'd0, e[W-1:0]});
        end
      end
      prev_start = add_start;
      if (res_valid && !prev_valid) begin
        first_valid_cyc = cyc;
        res_seen++;
      end
      prev_valid = res_valid;
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) check("res_unexpected", 32'd1, 32'd0);
        else check("res_sum", {16'd0, res_sum}, {16'd0, exp_q.pop_front()});
        check("res_timeout_err", {31'd0, timeout_err}, {31'd0, exp_err});
        hs_cnt++;
      end
    end else begin
      prev_start = 1'b0;
      prev_valid = 1'b0;
    end
  end

  // drivers
  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] s);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b;
    for (int k = 0; k < 200 && !in_ready; k++) @(negedge clk);
    if (!in_ready) check("push_ready_timeout", 32'd0, 32'd1);
    else begin
      acc_cyc = cyc;
      exp_q.push_back(s);
      exp_a_q.push_back({a, b});
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_hs(input int target, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (hs_cnt >= target) break;
    end
    if (hs_cnt < target) check("result_timeout", hs_cnt, target);
  endtask

  logic [W-1:0] t2a [6] = '{16'h0001, 16'h0010, 16'h0100, 16'h1000, 16'hABCD, 16'h7777};
  logic [W-1:0] t2b [6] = '{16'h0002, 16'h0020, 16'h0200, 16'h2000, 16'h1111, 16'h1111};
  logic [W-1:0] t2s [6] = '{16'h0003, 16'h0030, 16'h0300, 16'h3000, 16'hBCDE, 16'h8888};

  initial begin
    int accepted, refused, seen0;
    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
    check("rst_outs", {add_start, res_valid, busy, timeout_err, add_a, add_b}, 32'd0);
    check("rst_res_sum", {16'd0, res_sum}, 32'd0);
    @(negedge clk); reset = 1'b1;

    // 1: single op, start latency and one-cycle result
    push(16'h1234, 16'h5678, 16'h68AC);
    wait_hs(1, 100);
    check("t1_start_latency", start_cyc - acc_cyc, 32'd2);
    @(negedge clk); #1;
    check("t1_valid_one_cycle", {31'd0, res_valid}, 32'd0);

    // 2: fill FIFO with the result port stalled
    @(negedge clk); res_ready = 1'b0;
    accepted = 0; refused = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = t2a[i]; in_b = t2b[i];
      if (in_ready) begin
        accepted++;
        exp_q.push_back(t2s[i]);
        exp_a_q.push_back({t2a[i], t2b[i]});
      end else refused++;
    end
    @(negedge clk); in_valid = 1'b0; #1;
    check("t2_accepted", accepted, 32'd5);
    check("t2_refused", refused, 32'd1);
    check("t2_fifo_count", {29'd0, fifo_count}, 32'd4);
    check("t2_in_ready_full", {31'd0, in_ready}, 32'd0);
    res_ready = 1'b1;
    wait_hs(6, 600);

    // 3: overflow wraps without error
    push(16'hFFFF, 16'h0001, 16'h0000);
    wait_hs(7, 100);
    check("t3_no_err", {31'd0, timeout_err}, 32'd0);

    // 4: done left high from the previous op must not be captured
    stale_mode = 1'b1;
    push(16'h0005, 16'h0007, 16'h000C);
    wait_hs(8, 100);
    check("t4_capture_late", (first_valid_cyc - start_cyc) > 10, 32'd1);
    stale_mode = 1'b0;

    // 5: reset during WAIT flushes everything
    push(16'h2222, 16'h3333, 16'h5555);
    push(16'h4444, 16'h1111, 16'h5555);
    repeat (6) @(negedge clk);
    #1;
    check("t5_in_wait", {30'd0, dbg_state}, 32'd2);
    reset = 1'b0; #1;
    check("t5_fifo_count", {29'd0, fifo_count}, 32'd0);
    check("t5_outs", {add_start, res_valid, busy, timeout_err, add_a, add_b}, 32'd0);
    check("t5_res_sum", {16'd0, res_sum}, 32'd0);
    check("t5_in_ready", {31'd0, in_ready}, 32'd1);
    check("t5_state", {30'd0, dbg_state}, 32'd0);
    exp_q.delete(); exp_a_q.delete();
    @(negedge clk); reset = 1'b1;
    seen0 = res_seen;
    repeat (40) @(negedge clk);
    #1;
    check("t5_no_result", res_seen, seen0);
    check("t5_idle", {31'd0, busy}, 32'd0);

    // 6: adder never completes
    never_done = 1'b1;
    seen0 = res_seen;
`ifdef SEQ_TIMEOUT_EN
    exp_err = 1'b1;
    push(16'h0A0A, 16'h0505, 16'h0000);
    wait_hs(9, 200);
    check("t6_wait_cycles", first_valid_cyc - start_cyc, 32'd65);
    check("t6_sticky_err", {31'd0, timeout_err}, 32'd1);
`else
    push(16'h0A0A, 16'h0505, 16'h0000);
    repeat (150) @(negedge clk);
    #1;
    check("t6_busy", {31'd0, busy}, 32'd1);
    check("t6_no_result", res_seen, seen0);
    check("t6_no_err", {31'd0, timeout_err}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
